uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver; the downstream counterpart of uart_tx. It samples the asynchronous serial line `rx`, decodes 8N1 frames at BAUDRATE, and pushes received bytes into the shared `fifo` for the bus side to pop. It also flags framing errors and FIFO overruns as single-cycle pulses. Sits between the board RX pin and the CPU/bus peripheral logic.

Parameters:
SYS_CLK, 'd25_000_000, system clock frequency in Hz
BAUDRATE, 'd115200, line rate in bit/s; TICK = SYS_CLK/BAUDRATE clocks per bit (217 at defaults)

Ports:
i_clk  input  1  system clock; all logic on posedge
i_reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to i_clk
o_dat  output  8  FIFO head byte; valid only while o_fifo_empty=0
i_fifo_pop  input  1  one-cycle pulse; removes head byte
o_fifo_empty  output  1  1 = no received byte available
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: byte dropped because FIFO full

Behaviour:
- Reset (async, active-high): synchroniser flops = 1, state = IDLE, baud counter = 0, shift reg = 0, o_frame_err = 0, o_overrun = 0, FIFO emptied (o_fifo_empty = 1).
- Synchroniser: 2 flops on rx -> rx_s; all decoding uses rx_s only (2-cycle input latency).
- Baud counter: width $clog2(TICK)+1. Cleared on every state transition, otherwise increments.
- States:
  - IDLE: rx_s==0 -> STARTBIT.
  - STARTBIT: at counter==TICK/2-1 (mid start bit), sample rx_s. If 1 (glitch), go to IDLE with no output. If 0, go to DATA with bit index 0.
  - DATA: at counter==TICK-1, sample rx_s into shift reg, LSB first (bit index n -> shift[n]). After bit 7 -> STOPBIT; else bit index+1.
  - STOPBIT: at counter==TICK-1, sample rx_s, then go to IDLE. This is mid stop bit, half a bit early, which permits back-to-back frames.
    - rx_s==1 and FIFO not full: push shift reg (1-cycle i_push).
    - rx_s==1 and FIFO full: no push; o_overrun=1 for 1 cycle. FIFO contents unchanged.
    - rx_s==0: no push; o_frame_err=1 for 1 cycle. From IDLE, a new start is only detected after rx_s returns high then falls again (break condition generates one error only).
- Latency: push occurs ~9.5 bit times + 3 clocks after the start-bit falling edge on rx. o_fifo_empty falls per fifo timing.
- Simultaneous push and pop: both honoured by fifo. A pop when empty is ignored. A pop in the same cycle as a push into a full FIFO still counts the FIFO as full, so o_overrun fires.
- Reset mid-frame: the frame is aborted and no partial byte is pushed. After release, the remaining bits are treated as line activity. A falsely detected start may yield a frame_err; this is acceptable.
- Mid-bit resync is not performed. Tolerance is the standard ±~4% total baud mismatch.

Decomposition:
- Shared uart package/header: state encodings (IDLE, STARTBIT, DATA, STOPBIT) and the TICK/HALF_TICK localparam formula, so they are common with uart_tx.
- One sub-module: the existing `fifo` (i_clk, i_reset, i_dat, o_dat, i_push, i_pop, o_empty, o_full), instantiated as fifo0 with o_full used internally.
- The synchroniser is inline, not a separate module.

Test Plan:
- Single frame 0x55 at 217 clk/bit, idle high before/after -> exactly one push; o_dat=0x55; o_fifo_empty=0; error pulses never asserted. Pop -> o_fifo_empty=1.
- Back-to-back frames 0xA5, 0x3C, 0xFF with no idle gap -> FIFO yields 0xA5, 0x3C, 0xFF in order.
- rx low for 50 clocks then high (glitch < TICK/2) -> no push, no o_frame_err; state back in IDLE. A following 0x12 frame is received correctly.
- Frame 0x81 with stop bit driven low -> o_frame_err pulses once, FIFO stays empty. Line held low 5 bit times more -> no additional error. Release high, send 0x7E -> received.
- Send bytes 0x00, 0x01, ... without popping until o_full; send one more frame 0xEE -> o_overrun pulses once, 0xEE absent. Pop-all returns the original sequence intact.
- Assert i_reset during data bit 4 of frame 0xC3 -> immediately o_fifo_empty=1, no push. Loopback from uart_tx sending 0x5A after reset -> 0x5A received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, bit-timing formulas and
// the receive FIFO geometry.
package uart_rx_pkg;

  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STARTBIT = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_STOPBIT  = 2'd3;

  function automatic int calc_tick(int sys_clk, int baudrate);
    return sys_clk / baudrate;
  endfunction

  function automatic int calc_half_tick(int sys_clk, int baudrate);
    return calc_tick(sys_clk, baudrate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: serial line in, FIFO head and error
// pulses out. The receiver uses the slave modport, its consumer the master.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic              rx;
  logic [DATA_W-1:0] o_dat;
  logic              i_fifo_pop;
  logic              o_fifo_empty;
  logic              o_frame_err;
  logic              o_overrun;

  modport master (
    output rx, i_fifo_pop,
    input  o_dat, o_fifo_empty, o_frame_err, o_overrun
  );

  modport slave (
    input  rx, i_fifo_pop,
    output o_dat, o_fifo_empty, o_frame_err, o_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Power-of-two synchronous FIFO with show-ahead head byte. Pushes into a
// full FIFO and pops from an empty one are ignored.
module fifo #(
  parameter int DATA_W = 8,
  parameter int AW     = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_dat,
  input  logic              i_push,
  input  logic              i_pop,
  output logic              o_empty,
  output logic              o_full
);
  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_en;
  logic              rd_en;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // does not make room for a push into a full FIFO.
  assign wr_en   = i_push && !o_full;
  assign rd_en   = i_pop && !o_empty;
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_dat   = mem[rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_dat;
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, decodes frames with a mid-bit sampling
// FSM and queues bytes in fifo0, pulsing frame_err / overrun on bad frames.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYS_CLK  = 25_000_000,
  parameter int BAUDRATE = 115200
) (
  input logic      i_clk,
  input logic      i_reset,
  uart_rx_if.slave bus
);
  localparam int TICK      = calc_tick(SYS_CLK, BAUDRATE);
  localparam int HALF_TICK = calc_half_tick(SYS_CLK, BAUDRATE);
  localparam int CW        = $clog2(TICK) + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_TICK - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TICK - 1);

  logic              rx_m;
  logic              rx_s;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              armed;
  logic              push;
  logic              frame_err;
  logic              overrun;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      armed     <= 1'b1;
      push      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m      <= bus.rx;
      rx_s      <= rx_m;
      push      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= cnt + 1'b1;
      // A held-low break must return high before another start is accepted.
      if (rx_s) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!rx_s && armed) begin
            state <= ST_STARTBIT;
            cnt   <= '0;
          end
        end
        ST_STARTBIT: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= ST_STOPBIT;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_STOPBIT: begin
          // Sampled mid stop bit so a following start edge is never missed.
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end else if (full) begin
              overrun <= 1'b1;
            end else begin
              push <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) fifo0 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_dat   (shift),
    .o_dat   (head),
    .i_push  (push),
    .i_pop   (bus.i_fifo_pop),
    .o_empty (empty),
    .o_full  (full)
  );

  assign bus.o_dat        = head;
  assign bus.o_fifo_empty = empty;
  assign bus.o_frame_err  = frame_err;
  assign bus.o_overrun    = overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames and compares the FIFO contents and
// error pulse counts against a queue-based model of the receiver.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int TICK  = 25_000_000 / 115200;
  localparam int DEPTH = 1 << FIFO_AW;

  logic clk = 1'b0;
  logic rst;
  uart_rx_if bus ();

  always #5 clk = ~clk;

  uart_rx #(.SYS_CLK(25_000_000), .BAUDRATE(115200)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] model_q[$];
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  always @(negedge clk) begin
    if (bus.o_frame_err === 1'b1) ferr_cnt++;
    if (bus.o_overrun === 1'b1)   ovr_cnt++;
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    bus.rx = v;
    repeat (TICK) @(negedge clk);
  endtask

  // A frame with a good stop bit lands in the FIFO unless it is already full.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop)                     exp_ferr++;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else                           exp_ovr++;
  endtask

  task automatic pop_one(output logic [7:0] d, output logic e);
    @(negedge clk);
    d = bus.o_dat;
    e = bus.o_fifo_empty;
    bus.i_fifo_pop = 1'b1;
    @(negedge clk);
    bus.i_fifo_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL reset_empty: got %b expected 1", bus.o_fifo_empty);
    end
    compared++;
    if (bus.o_frame_err !== 1'b0 || bus.o_overrun !== 1'b0) begin
      mismatched++; $display("FAIL reset_pulses: got ferr=%b ovr=%b expected 0/0", bus.o_frame_err, bus.o_overrun);
    end
    rst = 1'b0;
    idle(TICK);
  endtask

  task automatic test_single();
    logic [7:0] d; logic e;
    send_byte(8'h55, 1'b1);
    idle(2 * TICK);
    compared++;
    if (bus.o_fifo_empty !== 1'b0 || bus.o_dat !== 8'h55) begin
      mismatched++; $display("FAIL single_head: got empty=%b dat=%h expected 0/55", bus.o_fifo_empty, bus.o_dat);
    end
    compared++;
    if (ferr_cnt !== 0 || ovr_cnt !== 0) begin
      mismatched++; $display("FAIL single_pulses: got ferr=%0d ovr=%0d expected 0/0", ferr_cnt, ovr_cnt);
    end
    pop_one(d, e);
    void'(model_q.pop_front());
    @(negedge clk);
    compared++;
    if (bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL single_pop_empty: got %b expected 1", bus.o_fifo_empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, exp; logic e;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(TICK);
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_one(d, e);
      compared++;
      if (e !== 1'b0 || d !== exp) begin
        mismatched++; $display("FAIL b2b_data: got empty=%b dat=%h expected 0/%h", e, d, exp);
      end
    end
    @(negedge clk);
    compared++;
    if (bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL b2b_drained: got %b expected 1", bus.o_fifo_empty);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d, exp; logic e;
    bus.rx = 1'b0;
    repeat (50) @(negedge clk);
    idle(2 * TICK);
    compared++;
    if (bus.o_fifo_empty !== 1'b1 || ferr_cnt !== exp_ferr) begin
      mismatched++; $display("FAIL glitch_ignored: got empty=%b ferr=%0d expected 1/%0d", bus.o_fifo_empty, ferr_cnt, exp_ferr);
    end
    send_byte(8'h12, 1'b1);
    idle(TICK);
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_one(d, e);
      compared++;
      if (e !== 1'b0 || d !== exp) begin
        mismatched++; $display("FAIL glitch_next: got empty=%b dat=%h expected 0/%h", e, d, exp);
      end
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d, exp; logic e;
    send_byte(8'h81, 1'b0);
    compared++;
    if (ferr_cnt !== exp_ferr || bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL ferr_once: got ferr=%0d empty=%b expected %0d/1", ferr_cnt, bus.o_fifo_empty, exp_ferr);
    end
    bus.rx = 1'b0;
    repeat (5 * TICK) @(negedge clk);
    compared++;
    if (ferr_cnt !== exp_ferr || bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL ferr_break: got ferr=%0d empty=%b expected %0d/1", ferr_cnt, bus.o_fifo_empty, exp_ferr);
    end
    idle(2 * TICK);
    send_byte(8'h7E, 1'b1);
    idle(TICK);
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_one(d, e);
      compared++;
      if (e !== 1'b0 || d !== exp) begin
        mismatched++; $display("FAIL ferr_recover: got empty=%b dat=%h expected 0/%h", e, d, exp);
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d, exp; logic e;
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b1);
    send_byte(8'hEE, 1'b1);
    idle(TICK);
    compared++;
    if (ovr_cnt !== exp_ovr || exp_ovr !== 1) begin
      mismatched++; $display("FAIL overrun_pulse: got %0d expected %0d", ovr_cnt, exp_ovr);
    end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_one(d, e);
      compared++;
      if (e !== 1'b0 || d !== exp) begin
        mismatched++; $display("FAIL overrun_data: got empty=%b dat=%h expected 0/%h", e, d, exp);
      end
    end
    @(negedge clk);
    compared++;
    if (bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL overrun_drained: got %b expected 1", bus.o_fifo_empty);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d, exp; logic e;
    logic [7:0] c3;
    c3 = 8'hC3;
    send_byte(8'h99, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    bus.rx = c3[4];
    repeat (TICK / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    model_q.delete();
    compared++;
    if (bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL midreset_empty: got %b expected 1", bus.o_fifo_empty);
    end
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(10 * TICK);
    compared++;
    if (bus.o_fifo_empty !== 1'b1 || ferr_cnt !== exp_ferr) begin
      mismatched++; $display("FAIL midreset_nopush: got empty=%b ferr=%0d expected 1/%0d", bus.o_fifo_empty, ferr_cnt, exp_ferr);
    end
    send_byte(8'h5A, 1'b1);
    idle(TICK);
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_one(d, e);
      compared++;
      if (e !== 1'b0 || d !== exp) begin
        mismatched++; $display("FAIL midreset_loop: got empty=%b dat=%h expected 0/%h", e, d, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, exp, b; logic e, bad;
    for (int n = 0; n < 6; n++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_byte(b, !bad);
      if (bad) idle(TICK);
      else     idle($urandom_range(0, TICK));
    end
    idle(TICK);
    compared++;
    if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
      mismatched++; $display("FAIL random_pulses: got ferr=%0d ovr=%0d expected %0d/%0d", ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
    end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      pop_one(d, e);
      compared++;
      if (e !== 1'b0 || d !== exp) begin
        mismatched++; $display("FAIL random_data: got empty=%b dat=%h expected 0/%h", e, d, exp);
      end
    end
    @(negedge clk);
    compared++;
    if (bus.o_fifo_empty !== 1'b1) begin
      mismatched++; $display("FAIL random_drained: got %b expected 1", bus.o_fifo_empty);
    end
  endtask

  initial begin
    bus.rx         = 1'b1;
    bus.i_fifo_pop = 1'b0;
    rst            = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
